// File: rtl/piso_serializer.sv
// LSB-first parallel-in/serial-out framer; first bit one en-strobe after accept, WIDTH bits per frame.
// Backpressure: din_ready only in IDLE, en==0 stalls the frame in place; `PARITY_SER_EN` appends an even-parity bit.
// Latency: word accepted at edge N -> bit 0 at edge N+1 (en held high), din_ready back after the last bit's edge.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_SER_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sdo_q, sdo_d;
    logic             vld_q, vld_d;
    logic             fs_q, fs_d;
`ifdef PARITY_SER_EN
    logic             par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sdo_q   <= 1'b0;
            vld_q   <= 1'b0;
            fs_q    <= 1'b0;
`ifdef PARITY_SER_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            sdo_q   <= sdo_d;
            vld_q   <= vld_d;
            fs_q    <= fs_d;
`ifdef PARITY_SER_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        sdo_d   = sdo_q;
        vld_d   = 1'b0;
        fs_d    = 1'b0;
`ifdef PARITY_SER_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (din_valid) begin
                    shreg_d = din;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef PARITY_SER_EN
                    // Parity is captured at accept so the shifted-out register is not needed later.
                    par_d   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (en) begin
                    sdo_d   = shreg_q[0];
                    vld_d   = 1'b1;
                    fs_d    = (cnt_q == '0);
                    shreg_d = shreg_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef PARITY_SER_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef PARITY_SER_EN
            PARITY: begin
                if (en) begin
                    sdo_d   = par_q;
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign din_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign sdo         = sdo_q;
    assign sdo_valid   = vld_q;
    assign frame_start = fs_q;

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of data bits per frame; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning reset: synchronous, active-low; clears state on a rising clk edge while rst==0.
REQ-004 The block SHALL have port din, input, WIDTH bits, meaning the parallel word to transmit.
REQ-005 The block SHALL have port din_valid, input, 1 bit, meaning din holds a word offered for transmission.
REQ-006 The block SHALL have port din_ready, output, 1 bit, meaning the block can accept a word this cycle.
REQ-007 The block SHALL have port en, input, 1 bit, meaning the bit-slot strobe: one serial bit advances per clk edge with en==1.
REQ-008 The block SHALL have port sdo, output, 1 bit, meaning the registered serial data bit.
REQ-009 The block SHALL have port sdo_valid, output, 1 bit, meaning sdo carries a new bit this cycle.
REQ-010 The block SHALL have port frame_start, output, 1 bit, meaning the current sdo bit is the first bit of a frame.
REQ-011 The block SHALL have port busy, output, 1 bit, meaning a frame is loaded and not yet fully shifted out.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT and, when PARITY_SER_EN is defined, PARITY.
REQ-013 The block SHALL drive din_ready=1 only in IDLE; busy SHALL equal (state != IDLE).
REQ-014 The block SHALL accept a word on a clk edge with din_valid==1 and din_ready==1: load shift register with din, clear bit counter, go to SHIFT.
REQ-015 The block SHALL ignore din and din_valid while not in IDLE; din_valid SHALL NOT be required to drop after acceptance.
REQ-016 The block SHALL, in SHIFT on each edge with en==1, register sdo<=shift_reg[0], set sdo_valid<=1, shift right by one, and increment the counter (LSB first).
REQ-017 The block SHALL set frame_start<=1 together with the bit whose counter value is 0, else 0.
REQ-018 The block SHALL, on any edge with en==0, set sdo_valid<=0 and frame_start<=0, hold sdo, shift register, counter and state unchanged.
REQ-019 The block SHALL leave SHIFT after emitting bit WIDTH-1: to PARITY if PARITY_SER_EN defined, else to IDLE on that same edge.
REQ-020 The block SHALL, in IDLE, drive sdo_valid=0 and frame_start=0 and hold sdo at its last value.
REQ-021 Latency: with en held 1, the first bit of a word accepted at edge N SHALL appear at edge N+1; din_ready SHALL return to 1 after edge N+WIDTH (N+WIDTH+1 with parity); minimum frame spacing is one IDLE cycle.
REQ-022 The block SHALL treat en==1 in IDLE as having no effect.

Reset
REQ-023 The block SHALL, on an edge with rst==0, force state=IDLE, sdo=0, sdo_valid=0, frame_start=0, counter=0, shift register=0, regardless of en or din_valid.
REQ-024 The block SHALL abort a frame in progress when reset is asserted mid-frame; no remaining bits SHALL be emitted and din_ready SHALL be 1 on the first cycle after rst returns to 1.

Configuration
REQ-025 With macro PARITY_SER_EN defined, the block SHALL emit one extra bit after bit WIDTH-1 in state PARITY on the next en==1 edge: even parity (XOR of all WIDTH data bits of the accepted word), sdo_valid=1, frame_start=0, then go to IDLE.
REQ-026 Without PARITY_SER_EN, the block SHALL contain no PARITY state or parity logic and frames SHALL be exactly WIDTH bits.

Verification
REQ-027 Reset: rst=0 for 2 edges with din_valid=1, en=1 -> sdo=0, sdo_valid=0, frame_start=0, busy=0, din_ready=1 after release.
REQ-028 Basic frame, WIDTH=8, no parity: din=8'hA5 accepted, en=1 -> sdo sequence 1,0,1,0,0,1,0,1 on 8 consecutive edges, frame_start only on first, din_ready=1 on next cycle.
REQ-029 Stalled strobe: din=8'h3C, en toggling 1,0,1,0 -> bits 0,0,1,1,1,1,0,0 emitted only on en==1 edges, sdo_valid=0 and sdo held on en==0 edges.
REQ-030 Back-to-back: din_valid held 1 with 8'hFF then 8'h00 -> second word accepted only after first completes and one IDLE cycle, frame_start asserted once per frame, no word lost or duplicated.
REQ-031 Mid-frame reset: rst=0 after 3 bits of 8'h81 -> no further sdo_valid, busy=0, next accepted word 8'h01 transmits from its bit 0 with frame_start=1.
REQ-032 PARITY_SER_EN defined: din=8'h07 -> 8 data bits then parity bit 1; din=8'h03 -> parity bit 0; busy=1 through the parity bit.
